// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types for the instruction fetch controller.
package fetch_ctrl_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_info_t;

    typedef enum logic [1:0] {RUN, WAIT, DRAIN, HALT} fetch_state_t;

    typedef struct packed {
        fetch_info_t info;
        logic        error;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two output buffer of fetched entries with push/pop/flush and occupancy count.
module fetch_fifo
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_entry;
                wr_d        = wr_q + 1'b1;
            end
            rd_d  = pop ? rd_q + 1'b1 : rd_q;
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and one-outstanding icache request sequencer feeding decode through fetch_fifo.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ic_req_valid,
    input  logic        ic_req_ready,
    output logic [31:0] ic_req_addr,
    input  logic        ic_rsp_valid,
    input  logic [31:0] ic_rsp_inst,
    input  logic        ic_rsp_error,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_info,
    output logic        out_error
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] NEAR = CW'(FIFO_DEPTH - 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d, addr_q, addr_d;
    logic          req_ok, push, pop;
    logic [CW-1:0] count;
    fetch_entry_t  head;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        push    = 1'b0;
        req_ok  = 1'b0;
        case (state_q)
            RUN:   req_ok = count < FULL;
            WAIT:  if (ic_rsp_valid) begin
                       push    = 1'b1;
                       state_d = ic_rsp_error ? HALT : RUN;
                       req_ok  = !ic_rsp_error && count < NEAR;
                   end
            DRAIN: state_d = ic_rsp_valid ? RUN : DRAIN;
            HALT:  state_d = HALT;
            default: state_d = RUN;
        endcase
        // A response arriving with the redirect retires the outstanding request.
        if (redirect_valid) begin
            req_ok  = 1'b0;
            push    = 1'b0;
            pc_d    = redirect_pc & ~32'h3;
            state_d = ((state_q == WAIT || state_q == DRAIN) && !ic_rsp_valid) ? DRAIN : RUN;
        end
        if (req_ok && ic_req_ready) begin
            pc_d    = pc_q + 32'd4;
            addr_d  = pc_q;
            state_d = WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(fetch_entry_t'({addr_q, ic_rsp_inst, ic_rsp_error})),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign ic_req_valid = req_ok && rst;
    assign ic_req_addr  = pc_q;
    assign out_valid    = count != '0;
    assign pop          = out_valid && out_ready;
    assign out_info     = out_valid ? head.info : '0;
    assign out_error    = out_valid && head.error;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d, stall_q, stall_d;

    always_comb begin
        fetched_d = fetched_q + {31'd0, pop};
        stall_d   = stall_q + {31'd0, state_q == RUN && count >= FULL};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= fetched_d;
            stall_q   <= stall_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized and directed checks of fetch_ctrl against a transaction-level fetch model.
module tb_fetch_ctrl;
    localparam int D = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_req_valid, ic_req_ready = 1'b0;
    logic [31:0] ic_req_addr;
    logic        ic_rsp_valid = 1'b0, ic_rsp_error = 1'b0;
    logic [31:0] ic_rsp_inst = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, out_ready = 1'b0, out_error;
    logic [63:0] out_info;

    fetch_ctrl #(.RESET_PC(32'h0), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_inst(ic_rsp_inst), .ic_rsp_error(ic_rsp_error),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_info(out_info), .out_error(out_error)
    );

    always #5 clk = ~clk;

    int vec = 0, errs = 0;
    int rdy_pct, ordy_pct, rd_pct, err_pct, lat_fix;
    bit rd_force = 0;
    logic [31:0] rd_pc_force, err_addr = 32'h1;

    // Reference model: architectural pc, outstanding request and expected FIFO contents.
    logic [31:0] pc_m, addr_m;
    bit out_m, drain_m, halt_m;
    ent_t q[$];

    // Icache responder.
    bit pend = 0;
    int lat = 0;
    logic [31:0] pend_addr;

    bit last_acc, saw_err;
    int nacc;
    logic [31:0] last_addr, err_pc;

    task automatic knobs(int r, int o, int rdp, int e, int l);
        rdy_pct = r; ordy_pct = o; rd_pct = rdp; err_pct = e; lat_fix = l;
    endtask

    task automatic do_reset(bit keep);
        @(negedge clk);
        rst = 1'b0; ic_req_ready = 0; ic_rsp_valid = 0; redirect_valid = 0; out_ready = 0;
        #1;
        vec++; if (ic_req_valid !== 1'b0) begin errs++; $display("FAIL reset_req_valid got %b exp 0", ic_req_valid); end
        vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        vec++; if (out_info !== 64'h0) begin errs++; $display("FAIL reset_out_info got %h exp 0", out_info); end
        vec++; if (out_error !== 1'b0) begin errs++; $display("FAIL reset_out_error got %b exp 0", out_error); end
        @(posedge clk);
        #1 rst = 1'b1;
        pc_m = 32'h0; out_m = 0; drain_m = 0; halt_m = 0; q.delete();
        if (!keep) pend = 0;
        last_acc = 0; nacc = 0; saw_err = 0;
    endtask

    task automatic step();
        bit rd, rv, re, acc, pop, exp_req;
        logic [31:0] rpc, inst, req_addr;
        @(negedge clk);
        rd  = rd_force || ($urandom_range(99) < rd_pct);
        rpc = rd_force ? rd_pc_force : ($urandom_range(3) == 0 ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom);
        rd_force = 0;
        redirect_valid = rd; redirect_pc = rpc;
        ic_req_ready = $urandom_range(99) < rdy_pct;
        out_ready    = $urandom_range(99) < ordy_pct;
        rv   = pend && lat == 0;
        re   = rv && (pend_addr == err_addr || $urandom_range(99) < err_pct);
        inst = $urandom;
        ic_rsp_valid = rv; ic_rsp_error = re; ic_rsp_inst = inst;
        #1;
        exp_req = !rd && !halt_m && !drain_m && (out_m ? (rv && !re && q.size() + 1 < D) : q.size() < D);
        vec++; if (ic_req_valid !== exp_req) begin errs++; $display("FAIL req_valid got %b exp %b", ic_req_valid, exp_req); end
        if (ic_req_valid) begin
            vec++; if (ic_req_addr !== pc_m) begin errs++; $display("FAIL req_addr got %h exp %h", ic_req_addr, pc_m); end
        end
        vec++; if (out_valid !== (q.size() != 0)) begin errs++; $display("FAIL out_valid got %b exp %b", out_valid, q.size() != 0); end
        if (q.size() != 0) begin
            vec++;
            if ({out_info, out_error} !== q[0]) begin
                errs++; $display("FAIL out_head got %h/%b exp %h/%b", out_info, out_error, {q[0].pc, q[0].inst}, q[0].err);
            end
        end
        acc = ic_req_valid && ic_req_ready;
        pop = out_valid && out_ready;
        req_addr = ic_req_addr;
        if (out_valid && out_error) begin saw_err = 1; err_pc = out_info[63:32]; end
        @(posedge clk);
        if (pop && q.size() != 0) void'(q.pop_front());
        if (rv && out_m) begin
            if (!rd && !drain_m) begin
                q.push_back({addr_m, inst, re});
                if (re) halt_m = 1;
            end
            out_m = 0; drain_m = 0;
        end
        if (acc) begin addr_m = pc_m; pc_m = pc_m + 32'd4; out_m = 1; end
        if (rd) begin q.delete(); pc_m = rpc & ~32'h3; halt_m = 0; if (out_m) drain_m = 1; end
        if (rv) pend = 0;
        else if (pend && lat > 0) lat--;
        if (acc) begin pend = 1; pend_addr = req_addr; lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(2)); end
        last_acc = acc;
        if (acc) begin last_addr = req_addr; nacc++; end
    endtask

    task automatic step_until_acc(string name);
        int n = 0;
        do begin step(); n++; end while (!last_acc && n < 30);
        if (!last_acc) begin vec++; errs++; $display("FAIL %s timeout waiting for request accept", name); end
    endtask

    task automatic test_reset();
        do_reset(0);
        knobs(0, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_stream();
        do_reset(0);
        knobs(100, 100, 0, 0, 0);
        repeat (40) step();
        vec++; if (nacc < 20) begin errs++; $display("FAIL stream_rate got %0d accepts exp >=20", nacc); end
        vec++; if (last_addr !== 32'(4 * (nacc - 1))) begin errs++; $display("FAIL stream_seq got %h exp %h", last_addr, 4 * (nacc - 1)); end
    endtask

    task automatic test_backpressure();
        do_reset(0);
        knobs(100, 0, 0, 0, 0);
        repeat (10) step();
        vec++; if (nacc != D) begin errs++; $display("FAIL bp_buffered got %0d exp %0d", nacc, D); end
        knobs(100, 100, 0, 0, 0);
        step_until_acc("bp_resume");
        vec++; if (last_addr !== 32'h8) begin errs++; $display("FAIL bp_resume_addr got %h exp 00000008", last_addr); end
    endtask

    task automatic test_redirect_wait();
        do_reset(0);
        knobs(100, 100, 0, 0, 2);
        step_until_acc("rdw_first");
        rd_force = 1; rd_pc_force = 32'h0000_1003;
        step();
        step_until_acc("rdw_next");
        vec++; if (last_addr !== 32'h1000) begin errs++; $display("FAIL rdw_addr got %h exp 00001000", last_addr); end
    endtask

    task automatic test_redirect_rsp();
        do_reset(0);
        knobs(100, 0, 0, 0, 0);
        step_until_acc("rdr_first");
        rd_force = 1; rd_pc_force = 32'h0000_1000;
        step();
        #1;
        vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rdr_flush got %b exp 0", out_valid); end
        knobs(100, 100, 0, 0, 0);
        step_until_acc("rdr_next");
        vec++; if (last_addr !== 32'h1000) begin errs++; $display("FAIL rdr_addr got %h exp 00001000", last_addr); end
    endtask

    task automatic test_error();
        int n = 0, quiet = 0;
        do_reset(0);
        knobs(100, 100, 0, 0, 0);
        err_addr = 32'hC;
        do begin step(); n++; end while (!saw_err && n < 40);
        vec++; if (!saw_err || err_pc !== 32'hC) begin errs++; $display("FAIL err_head got %b/%h exp 1/0000000c", saw_err, err_pc); end
        repeat (8) begin step(); quiet += int'(last_acc); end
        vec++; if (quiet != 0) begin errs++; $display("FAIL err_halt got %0d accepts exp 0", quiet); end
        err_addr = 32'h1;
        rd_force = 1; rd_pc_force = 32'h40;
        step_until_acc("err_resume");
        vec++; if (last_addr !== 32'h40) begin errs++; $display("FAIL err_resume_addr got %h exp 00000040", last_addr); end
    endtask

    task automatic test_wrap();
        logic [31:0] first;
        do_reset(0);
        knobs(100, 100, 0, 0, 0);
        rd_force = 1; rd_pc_force = 32'hFFFF_FFFC;
        step();
        step_until_acc("wrap_first");
        first = last_addr;
        step_until_acc("wrap_second");
        vec++; if (first !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_first got %h exp fffffffc", first); end
        vec++; if (last_addr !== 32'h0) begin errs++; $display("FAIL wrap_second got %h exp 00000000", last_addr); end
    endtask

    task automatic test_rst_mid();
        do_reset(0);
        knobs(100, 100, 0, 0, 1);
        step_until_acc("rst_mid_first");
        do_reset(1);
        knobs(0, 100, 0, 0, 0);
        repeat (3) step();
        vec++; if (pend) begin errs++; $display("FAIL rst_mid_stray got pending=1 exp 0"); end
        knobs(100, 100, 0, 0, 0);
        step_until_acc("rst_mid_resume");
        vec++; if (last_addr !== 32'h0) begin errs++; $display("FAIL rst_mid_addr got %h exp 00000000", last_addr); end
        repeat (4) step();
    endtask

    task automatic test_random();
        do_reset(0);
        knobs(70, 60, 4, 3, -1);
        repeat (3000) step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp();
        test_error();
        test_wrap();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
